// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, counter widths and the
// half-bit helper used by both the transmitter and the receiver.
package uart_pkg;

   localparam int BAUD_CNT_W = 13;
   localparam int BIT_CNT_W  = 3;
   localparam int STATE_W    = 3;

   typedef logic [BAUD_CNT_W-1:0] baud_cnt_t;
   typedef logic [BIT_CNT_W-1:0]  bit_cnt_t;
   typedef logic [STATE_W-1:0]    state_t;

   localparam state_t ST_IDLE    = 3'd0;
   localparam state_t ST_START   = 3'd1;
   localparam state_t ST_RX_B    = 3'd2;
   localparam state_t ST_STOP    = 3'd3;
   localparam state_t ST_WAIT_HI = 3'd4;

   localparam bit_cnt_t BIT_CNT_LAST = 3'd7;

   // Half a bit period, used to land the start-bit check at the bit centre.
   function automatic baud_cnt_t half_bit(input baud_cnt_t full);
      return {1'b0, full[BAUD_CNT_W-1:1]};
   endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receive-side byte handshake between uart_rx (master) and its consumer (slave).
interface uart_rx_if;

   logic [7:0] rx_byte;
   logic       rx_byte_dv;
   logic       rx_byte_rd;
   logic       rx_overrun;
   logic       rx_frame_err;

   modport master (
      output rx_byte,
      output rx_byte_dv,
      output rx_overrun,
      output rx_frame_err,
      input  rx_byte_rd
   );

   modport slave (
      input  rx_byte,
      input  rx_byte_dv,
      input  rx_overrun,
      input  rx_frame_err,
      output rx_byte_rd
   );

endinterface

// File: rtl/uart_sync.sv
// Multi-flop bit synchronizer with a configurable reset value.
module uart_sync #(
   parameter int   STAGES    = 2,
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sync_r;

   // Shift the asynchronous input through the synchronizer chain.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_r <= {STAGES{RESET_VAL}};
      end else begin
         sync_r <= {sync_r[STAGES-2:0], d};
      end
   end

   assign q = sync_r[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1, LSB first, centre sampling with a down-counter.
// Optional feature macro: UART_RX_FRAME_ERR_EN (enables the rx_frame_err pulse).
module uart_rx
   import uart_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rxd,
   input  logic [BAUD_CNT_W-1:0] baud_clk_cnt,
   input  logic                  en,
   uart_rx_if.master             rx
);

`ifdef UART_RX_FRAME_ERR_EN
   localparam logic FRAME_ERR_EN = 1'b1;
`else
   localparam logic FRAME_ERR_EN = 1'b0;
`endif

   logic       clr_s;
   logic       rxd_s;
   state_t     state_r;
   baud_cnt_t  cnt_r;
   bit_cnt_t   bit_cnt_r;
   logic [7:0] shift_r;
   logic [7:0] rx_byte_r;
   logic       rx_byte_dv_r;
   logic       rx_overrun_r;
   logic       rx_frame_err_r;

   // Disabling the block is indistinguishable from holding it in reset.
   assign clr_s = rst | ~en;

   uart_sync #(
      .STAGES    (SYNC_STAGES),
      .RESET_VAL (1'b1)
   ) u_sync (
      .clk (clk),
      .rst (clr_s),
      .d   (rxd),
      .q   (rxd_s)
   );

   // Frame FSM, bit timing, shift register and the output byte handshake.
   always_ff @(posedge clk) begin
      if (clr_s) begin
         state_r        <= ST_IDLE;
         cnt_r          <= 13'd0;
         bit_cnt_r      <= 3'd0;
         shift_r        <= 8'h00;
         rx_byte_r      <= 8'h00;
         rx_byte_dv_r   <= 1'b0;
         rx_overrun_r   <= 1'b0;
         rx_frame_err_r <= 1'b0;
      end else begin
         rx_overrun_r   <= 1'b0;
         rx_frame_err_r <= 1'b0;
         if (rx_byte_rd_ok(rx.rx_byte_rd, rx_byte_dv_r)) begin
            rx_byte_dv_r <= 1'b0;
         end
         case (state_r)
            ST_IDLE: begin
               if (!rxd_s) begin
                  cnt_r   <= half_bit(baud_clk_cnt);
                  state_r <= ST_START;
               end
            end
            ST_START: begin
               if (cnt_r != 13'd0) begin
                  cnt_r <= cnt_r - 13'd1;
               end else if (!rxd_s) begin
                  cnt_r     <= baud_clk_cnt;
                  bit_cnt_r <= BIT_CNT_LAST;
                  state_r   <= ST_RX_B;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_RX_B: begin
               if (cnt_r != 13'd0) begin
                  cnt_r <= cnt_r - 13'd1;
               end else begin
                  shift_r <= {rxd_s, shift_r[7:1]};
                  cnt_r   <= baud_clk_cnt;
                  if (bit_cnt_r != 3'd0) begin
                     bit_cnt_r <= bit_cnt_r - 3'd1;
                  end else begin
                     state_r <= ST_STOP;
                  end
               end
            end
            ST_STOP: begin
               if (cnt_r != 13'd0) begin
                  cnt_r <= cnt_r - 13'd1;
               end else if (rxd_s) begin
                  // A read in this very cycle hands over cleanly: no overrun.
                  rx_byte_r    <= shift_r;
                  rx_byte_dv_r <= 1'b1;
                  rx_overrun_r <= rx_byte_dv_r & ~rx.rx_byte_rd;
                  state_r      <= ST_IDLE;
               end else begin
                  rx_frame_err_r <= FRAME_ERR_EN;
                  state_r        <= ST_WAIT_HI;
               end
            end
            ST_WAIT_HI: begin
               if (rxd_s) begin
                  state_r <= ST_IDLE;
               end
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   function automatic logic rx_byte_rd_ok(input logic rd, input logic dv);
      return rd & dv;
   endfunction

   assign rx.rx_byte      = rx_byte_r;
   assign rx.rx_byte_dv   = rx_byte_dv_r;
   assign rx.rx_overrun   = rx_overrun_r;
   assign rx.rx_frame_err = rx_frame_err_r;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus random frames,
// compared against a frame-level reference model kept in the bench.
module tb_uart_rx;

`ifdef UART_RX_FRAME_ERR_EN
   localparam int FE_EN = 1;
`else
   localparam int FE_EN = 0;
`endif

   localparam int BIT_CLKS = 10;
   // Negedge index (from the start edge) at which the stop-bit sample lands:
   // 9.5 bit periods + synchronizer latency + one FSM edge.
   localparam int DONE_IDX = 98;

   logic        clk;
   logic        rst;
   logic        rxd;
   logic [12:0] baud_clk_cnt;
   logic        en;

   uart_rx_if rx_if ();

   uart_rx #(.SYNC_STAGES(2)) dut (
      .clk          (clk),
      .rst          (rst),
      .rxd          (rxd),
      .baud_clk_cnt (baud_clk_cnt),
      .en           (en),
      .rx           (rx_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;
   int ovr_cnt     = 0;
   int fe_cnt      = 0;

   logic [7:0] exp_byte = 8'h00;
   logic       exp_dv   = 1'b0;
   int         exp_ovr  = 0;
   int         exp_fe   = 0;

   // Pulse counters: a stuck pulse shows up as an excess count.
   always @(negedge clk) begin
      if (rx_if.rx_overrun === 1'b1) ovr_cnt <= ovr_cnt + 1;
      if (rx_if.rx_frame_err === 1'b1) fe_cnt <= fe_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_state(input string tag);
      chk({tag, ".rx_byte"}, {24'd0, rx_if.rx_byte}, {24'd0, exp_byte});
      chk({tag, ".rx_byte_dv"}, {31'd0, rx_if.rx_byte_dv}, {31'd0, exp_dv});
      chk({tag, ".overruns"}, ovr_cnt, exp_ovr);
      chk({tag, ".frame_errs"}, fe_cnt, exp_fe);
   endtask

   // Drive one 8N1 frame from a negedge; optionally pulse rx_byte_rd at negedge rd_at.
   task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                             input int rd_at, output int lat);
      int l;
      l = -1;
      fork
         begin
            rxd = 1'b0;
            repeat (BIT_CLKS) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
               rxd = b[i];
               repeat (BIT_CLKS) @(negedge clk);
            end
            rxd = stop_bit;
            repeat (BIT_CLKS) @(negedge clk);
            rxd = 1'b1;
            repeat (15) @(negedge clk);
         end
         begin
            for (int k = 1; k <= 115; k++) begin
               @(negedge clk);
               if (rx_if.rx_byte_dv === 1'b1 && l < 0) l = k;
               rx_if.rx_byte_rd = (k == rd_at);
            end
            rx_if.rx_byte_rd = 1'b0;
         end
      join
      lat = l;
   endtask

   // Frame-level model: a read ahead of completion empties the buffer, a read
   // in the completion cycle hands over, a later read consumes the new byte.
   task automatic apply_frame(input string tag, input logic [7:0] b,
                              input logic stop_bit, input int rd_at);
      int lat;
      send_frame(b, stop_bit, rd_at, lat);
      if (stop_bit) begin
         if (rd_at > 0 && rd_at < DONE_IDX - 1) exp_dv = 1'b0;
         if (exp_dv && rd_at != DONE_IDX - 1) exp_ovr++;
         exp_byte = b;
         exp_dv   = 1'b1;
         if (rd_at >= DONE_IDX) exp_dv = 1'b0;
      end else begin
         if (rd_at > 0) exp_dv = 1'b0;
         exp_fe += FE_EN;
      end
      check_state(tag);
   endtask

   task automatic read_byte(input string tag);
      rx_if.rx_byte_rd = 1'b1;
      @(negedge clk);
      rx_if.rx_byte_rd = 1'b0;
      exp_dv = 1'b0;
      chk({tag, ".dv_cleared"}, {31'd0, rx_if.rx_byte_dv}, 32'd0);
   endtask

   task automatic abort_frame(input string tag, input logic use_rst);
      rxd = 1'b0;
      repeat (BIT_CLKS) @(negedge clk);
      rxd = 1'b1;
      repeat (4 * BIT_CLKS + 5) @(negedge clk);
      if (use_rst) begin
         rst = 1'b1;
         @(negedge clk);
         rst = 1'b0;
      end else begin
         en = 1'b0;
         repeat (5) @(negedge clk);
         en = 1'b1;
      end
      repeat (120) @(negedge clk);
      exp_byte = 8'h00;
      exp_dv   = 1'b0;
      check_state(tag);
   endtask

   initial begin
      int lat;
      logic [7:0] rb;
      logic       rs;
      int         ra;

      rst = 1'b1;
      en = 1'b1;
      rxd = 1'b1;
      baud_clk_cnt = 13'd9;
      rx_if.rx_byte_rd = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_state("reset");

      // Good frame, with first-byte latency measured from the start edge.
      send_frame(8'hA5, 1'b1, -1, lat);
      exp_byte = 8'hA5;
      exp_dv   = 1'b1;
      check_state("a5");
      chk("a5.dv_latency_window", {31'd0, (lat >= 97 && lat <= 99)}, 32'd1);
      read_byte("a5");

      // Start-bit glitch must be rejected.
      rxd = 1'b0;
      repeat (3) @(negedge clk);
      rxd = 1'b1;
      repeat (20) @(negedge clk);
      check_state("glitch");
      apply_frame("3c", 8'h3C, 1'b1, -1);
      read_byte("3c");

      // Bad stop bit, then recovery.
      apply_frame("81_badstop", 8'h81, 1'b0, -1);
      apply_frame("42", 8'h42, 1'b1, -1);
      read_byte("42");

      // Back-to-back without reads: one overrun.
      apply_frame("11", 8'h11, 1'b1, -1);
      apply_frame("22_overrun", 8'h22, 1'b1, -1);

      // Read in the same cycle the next byte completes: no overrun.
      apply_frame("5a_coincident", 8'h5A, 1'b1, DONE_IDX - 1);

      // Aborts with an unread byte pending.
      abort_frame("abort_en", 1'b0);
      apply_frame("0f", 8'h0F, 1'b1, -1);
      abort_frame("abort_rst", 1'b1);
      apply_frame("f0", 8'hF0, 1'b1, -1);

      for (int n = 0; n < 12; n++) begin
         rb = 8'($urandom_range(0, 255));
         rs = ($urandom_range(0, 3) != 0);
         ra = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(1, 115));
         apply_frame($sformatf("rand%0d", n), rb, rs, ra);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
